// File: rtl/ddc_arith_pkg.sv
// Shared arithmetic definitions for the DDC datapath: rounding mode codes and
// the width of the rounded intermediate used by the multiplier and filter output stages.
package ddc_arith_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;
    localparam int ROUND_CONV    = 2;

    // One guard bit above the kept product bits absorbs the rounding carry.
    function automatic int round_width(input int p_width, input int shift);
        return p_width - shift + 1;
    endfunction

endpackage

// File: rtl/round_sat.sv
// Round-and-saturate stage: discards SHIFT LSBs of a product with selectable rounding,
// then clamps to the output width. One register after rounding, one after saturation.
module round_sat
    import ddc_arith_pkg::*;
#(
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 16,
    parameter int O_WIDTH    = 16,
    parameter int SHIFT      = 15,
    parameter int SIGNED     = 1,
    parameter int ROUND_MODE = ROUND_CONV
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic [A_WIDTH+B_WIDTH-1:0] p_i,
    output logic                       valid_o,
    output logic [O_WIDTH-1:0]         mult_o,
    output logic                       ovf_o
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int RW = round_width(PW, SHIFT);
    localparam int EW = ((RW > O_WIDTH) ? RW : O_WIDTH) + 1;

    logic [PW:0]              w_p_ext;
    logic [RW-1:0]            w_r_floor;
    logic [RW-1:0]            w_r_round;
    logic                     w_half;
    logic                     w_sticky;
    logic                     w_inc;

    logic [RW-1:0]            r_round;
    logic                     r_round_vld;

    logic signed [EW-1:0]     w_ext;
    logic signed [EW-1:0]     w_max;
    logic signed [EW-1:0]     w_min;
    logic [O_WIDTH-1:0]       w_sat;
    logic                     w_ovf;

    logic                     r_vld;
    logic [O_WIDTH-1:0]       r_mult;
    logic                     r_ovf;

    // Floor shift plus the rounding increment chosen by the half bit and sticky bits.
    always_comb begin
        w_p_ext   = (SIGNED != 0) ? {p_i[PW-1], p_i} : {1'b0, p_i};
        w_r_floor = w_p_ext[PW:SHIFT];
        w_half    = 1'b0;
        w_sticky  = 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (i == SHIFT - 1) begin
                w_half = w_p_ext[i];
            end else if (i < SHIFT - 1) begin
                w_sticky = w_sticky | w_p_ext[i];
            end else begin
                w_sticky = w_sticky;
            end
        end
        case (ROUND_MODE)
            ROUND_HALF_UP: w_inc = w_half;
            ROUND_CONV:    w_inc = w_half & (w_sticky | w_r_floor[0]);
            default:       w_inc = 1'b0;
        endcase
        w_r_round = w_r_floor + {{(RW-1){1'b0}}, w_inc};
    end

    // Round register; data is left unreset so it can sit in a DSP output register.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_round <= w_r_round;
        end
    end

    // Valid bit matching the round register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_round_vld <= 1'b0;
        end else if (en_i) begin
            r_round_vld <= valid_i;
        end
    end

    // Compare in a width wide enough for both the rounded value and the output limits.
    always_comb begin
        if (SIGNED != 0) begin
            w_ext = {{(EW-RW){r_round[RW-1]}}, r_round};
            w_max = (EW'(1'b1) << (O_WIDTH - 1)) - EW'(1'b1);
            w_min = -(EW'(1'b1) << (O_WIDTH - 1));
        end else begin
            w_ext = {{(EW-RW){1'b0}}, r_round};
            w_max = (EW'(1'b1) << O_WIDTH) - EW'(1'b1);
            w_min = '0;
        end
        if (w_ext > w_max) begin
            w_sat = w_max[O_WIDTH-1:0];
            w_ovf = 1'b1;
        end else if (w_ext < w_min) begin
            w_sat = w_min[O_WIDTH-1:0];
            w_ovf = 1'b1;
        end else begin
            w_sat = w_ext[O_WIDTH-1:0];
            w_ovf = 1'b0;
        end
    end

    // Output register; cleared on reset so no stale sample is presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld  <= 1'b0;
            r_mult <= '0;
            r_ovf  <= 1'b0;
        end else if (en_i) begin
            r_vld  <= r_round_vld;
            r_mult <= w_sat;
            r_ovf  <= w_ovf;
        end
    end

    assign valid_o = r_vld;
    assign mult_o  = r_mult;
    assign ovf_o   = r_ovf;

endmodule

// File: rtl/mult_round_sat.sv
// Pipelined fixed-point multiplier for the DDC datapath: input register, product
// register, optional retiming delays, then the shared round/saturate stage.
module mult_round_sat
    import ddc_arith_pkg::*;
#(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int O_WIDTH     = 16,
    parameter int SHIFT       = 15,
    parameter int SIGNED      = 1,
    parameter int ROUND_MODE  = ROUND_CONV,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic [A_WIDTH-1:0] a_i,
    input  logic [B_WIDTH-1:0] b_i,
    output logic               valid_o,
    output logic [O_WIDTH-1:0] mult_o,
    output logic               ovf_o
);

    localparam int PW = A_WIDTH + B_WIDTH;

    logic [A_WIDTH-1:0]     r_a;
    logic [B_WIDTH-1:0]     r_b;
    logic                   r_vld_in;
    logic [PW-1:0]          w_a_ext;
    logic [PW-1:0]          w_b_ext;
    logic [PW-1:0]          w_prod;
    logic [PW-1:0]          r_dly [0:PIPE_STAGES];
    logic [PIPE_STAGES:0]   r_vld_dly;

    // Extending both operands to the product width gives the exact product in the low bits.
    always_comb begin
        w_a_ext = {{B_WIDTH{(SIGNED != 0) && r_a[A_WIDTH-1]}}, r_a};
        w_b_ext = {{A_WIDTH{(SIGNED != 0) && r_b[B_WIDTH-1]}}, r_b};
        w_prod  = w_a_ext * w_b_ext;
    end

    // Operand, product and retiming registers; no reset so they map onto DSP registers.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_dly[0] <= w_prod;
            for (int i = 1; i <= PIPE_STAGES; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Valid chain mirroring the data registers above.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_in  <= 1'b0;
            r_vld_dly <= '0;
        end else if (en_i) begin
            r_vld_in     <= valid_i;
            r_vld_dly[0] <= r_vld_in;
            for (int i = 1; i <= PIPE_STAGES; i++) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
            end
        end
    end

    round_sat #(
        .A_WIDTH    (A_WIDTH),
        .B_WIDTH    (B_WIDTH),
        .O_WIDTH    (O_WIDTH),
        .SHIFT      (SHIFT),
        .SIGNED     (SIGNED),
        .ROUND_MODE (ROUND_MODE)
    ) u_round_sat (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .valid_i (r_vld_dly[PIPE_STAGES]),
        .p_i     (r_dly[PIPE_STAGES]),
        .valid_o (valid_o),
        .mult_o  (mult_o),
        .ovf_o   (ovf_o)
    );

endmodule
